// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: widths, op encodings, FSM states.
// The instruction decoder imports the same op encodings.
package muldiv_pkg;

    localparam int unsigned MULDIV_XLEN  = 32;
    localparam int unsigned MULDIV_CNT_W = 5;

    localparam logic [1:0] MULDIV_MUL   = 2'b00;
    localparam logic [1:0] MULDIV_MULHU = 2'b01;
    localparam logic [1:0] MULDIV_DIVU  = 2'b10;
    localparam logic [1:0] MULDIV_REMU  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit (shift-add / restoring), one bit per cycle.
// Stalls the core while busy and presents a single-cycle regfile writeback in DONE.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = MULDIV_XLEN,
    parameter int unsigned CNT_W = MULDIV_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [XLEN-1:0]  operand_a,
    input  logic [XLEN-1:0]  operand_b,
    input  logic [4:0]       dest_reg,
    output logic             stall,
    output logic             wb_enable,
    output logic [4:0]       wb_reg,
    output logic [XLEN-1:0]  wb_data
);

    logic [1:0]      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] b_q, b_d;
    // acc_hi holds hi (multiply) or R (divide); both stay below 2**XLEN between iterations,
    // so only the per-iteration intermediate needs the extra bit.
    logic [XLEN-1:0] acc_hi_q, acc_hi_d;
    logic [XLEN-1:0] acc_lo_q, acc_lo_d;
    logic [4:0]      wb_reg_q, wb_reg_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;

    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi_nx, mul_lo_nx;
    logic [XLEN:0]   div_r_sh, div_diff;
    logic            div_borrow;
    logic [XLEN-1:0] div_r_nx, div_q_nx;
    logic [XLEN-1:0] hi_nx, lo_nx, result;

    // One iteration of both datapaths; op_q[1] picks divide.
    always_comb begin
        mul_sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
        mul_hi_nx  = mul_sum[XLEN:1];
        mul_lo_nx  = {mul_sum[0], acc_lo_q[XLEN-1:1]};

        div_r_sh   = {acc_hi_q, acc_lo_q[XLEN-1]};
        div_diff   = div_r_sh - {1'b0, b_q};
        div_borrow = div_diff[XLEN];
        div_r_nx   = div_borrow ? div_r_sh[XLEN-1:0] : div_diff[XLEN-1:0];
        div_q_nx   = {acc_lo_q[XLEN-2:0], ~div_borrow};

        hi_nx = op_q[1] ? div_r_nx : mul_hi_nx;
        lo_nx = op_q[1] ? div_q_nx : mul_lo_nx;

        case (op_q)
            MULDIV_MUL:   result = mul_lo_nx;
            MULDIV_MULHU: result = mul_hi_nx;
            MULDIV_DIVU:  result = div_q_nx;
            default:      result = div_r_nx;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        b_d       = b_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        wb_reg_d  = wb_reg_q;
        wb_data_d = wb_data_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d     = op;
                    b_d      = operand_b;
                    wb_reg_d = dest_reg;
                    cnt_d    = '0;
                    if (op[1] && (operand_b == '0)) begin
                        state_d   = ST_DONE;
                        wb_data_d = (op == MULDIV_DIVU) ? '1 : operand_a;
                    end else begin
                        state_d  = ST_BUSY;
                        acc_hi_d = '0;
                        acc_lo_d = operand_a;
                    end
                end
            end
            ST_BUSY: begin
                acc_hi_d = hi_nx;
                acc_lo_d = lo_nx;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == '1) begin
                    state_d   = ST_DONE;
                    wb_data_d = result;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            b_q       <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            wb_reg_q  <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            b_q       <= b_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            wb_reg_q  <= wb_reg_d;
            wb_data_q <= wb_data_d;
        end
    end

    // Gated by reset so the core is never stalled while the unit is held in reset.
    assign stall     = ~reset && (((state_q == ST_IDLE) && start) || (state_q == ST_BUSY));
    assign wb_enable = ~reset && (state_q == ST_DONE) && (wb_reg_q != 5'd0);
    assign wb_reg    = wb_reg_q;
    assign wb_data   = wb_data_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative 32-bit unsigned multiply/divide unit.
- Sits directly upstream of the register-file write port. Its operands come from regfile read_data1/read_data2, and its outputs drive write_reg, write_data and write_enable when the control mux selects it.
- Stalls the single-cycle core while computing, then presents one writeback for exactly one cycle.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 5, iteration counter width; XLEN must equal 2**CNT_W.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  muldiv instruction present in decode; level, held by core while stalled
- op  in  2  00 MUL (low product), 01 MULHU (high product), 10 DIVU (quotient), 11 REMU (remainder)
- operand_a  in  XLEN  rs1 value (multiplicand/dividend)
- operand_b  in  XLEN  rs2 value (multiplier/divisor)
- dest_reg  in  5  destination register index
- stall  out  1  hold PC/fetch this cycle
- wb_enable  out  1  regfile write strobe
- wb_reg  out  5  regfile write index
- wb_data  out  XLEN  result

Behaviour:
- Reset: asynchronous, active-high.
  - State goes to IDLE. Counter, accumulators, wb_reg and wb_data go to 0.
  - wb_enable=0 and stall=0 while reset is high.
- States: IDLE, BUSY, DONE.
- Accept rule: start && state==IDLE.
  - Latch op, operand_a, operand_b and dest_reg on that edge.
  - Operands need not be held afterwards.
- IDLE -> BUSY on accept, except divide-by-zero, which goes IDLE -> DONE.
- BUSY:
  - Counter runs 0..XLEN-1, one iteration per cycle.
  - After the iteration with counter==XLEN-1, go to DONE.
- DONE -> IDLE unconditionally after one cycle. start is ignored in DONE and BUSY.
- stall, combinational: (state==IDLE && start) || state==BUSY.
  - stall is low in DONE, so the PC advances on the same edge the regfile writes.
- wb_enable, combinational: state==DONE && wb_reg!=0. Writes to x0 are suppressed at the source.
- wb_reg and wb_data are registered and stable throughout DONE.
- Latency:
  - Normal op: start seen in IDLE -> 32 BUSY cycles -> DONE. Writeback lands on the edge ending DONE; total 34 cycles start-to-retire.
  - Divide-by-zero: 2 cycles.
- Multiply (shift-add):
  - 65-bit accumulator {carry, hi, lo}; initial hi=0, lo=operand_a.
  - Each iteration: if lo[0], hi += b (33-bit sum); then shift {carry,hi,lo} right 1.
  - MUL returns lo; MULHU returns hi.
- Divide (restoring):
  - 33-bit remainder R=0, quotient Q=operand_a.
  - Each iteration: {R,Q} <<= 1; if R >= b then R -= b and Q[0]=1.
  - DIVU returns Q; REMU returns R[31:0].
- Divide by zero, detected at accept: DIVU returns 0xFFFFFFFF; REMU returns operand_a. No iterations are run.
- No overflow cases exist (unsigned only).
- Reset asserted in BUSY or DONE:
  - Computation is abandoned with no writeback.
  - After release the unit is in IDLE. If start is still high it re-accepts on the next edge.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings MULDIV_MUL/MULHU/DIVU/REMU.
  - State encodings.
  - XLEN constant.
  - The decoder uses the same op constants.
- Single module. The iteration datapath is two small always blocks; no sub-module is warranted.

Test Plan:
- MUL 7*6, dest_reg=5:
  - stall high for 33 cycles.
  - wb_enable high exactly 1 cycle with wb_reg=5, wb_data=42.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> wb_data=0xFFFFFFFE. MUL with the same operands -> 0x00000001.
- DIVU 100/7 -> 14; REMU 100/7 -> 2. Both at cycle 34 from start.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - stall high only in the accept cycle.
  - wb_enable in the following cycle.
- dest_reg=0, MUL 3*3:
  - Full 34-cycle timing is preserved.
  - wb_enable never asserts.
- Mid-operation reset:
  - Start MUL to reg 3 and pulse reset at BUSY iteration 10.
  - Outputs go to 0 immediately and there is no wb_enable.
  - With start still high after release, a fresh 34-cycle operation completes correctly.
